// File: rtl/pipe_regfile_sb.sv
// pipe_regfile_sb: GPR/HI/LO register file with WB write-through bypass and a busy-bit scoreboard for long-latency results.
module pipe_regfile_sb #(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Ww_rf,
  input  logic [4:0]      Wrn,
  input  logic [DW-1:0]   Wdata_rf,
  input  logic            Ww_hi,
  input  logic [DW-1:0]   Wdata_hi,
  input  logic            Ww_lo,
  input  logic [DW-1:0]   Wdata_lo,
  input  logic [4:0]      rs,
  input  logic [4:0]      rt,
  input  logic            rs_used,
  input  logic            rt_used,
  input  logic            issue,
  input  logic            issue_long,
  input  logic [4:0]      issue_rn,
  output logic [DW-1:0]   qa,
  output logic [DW-1:0]   qb,
  output logic [DW-1:0]   hi_out,
  output logic [DW-1:0]   lo_out,
  output logic            stall,
  output logic [NREG-1:0] busy
);
  logic [DW-1:0]   r_gpr [NREG];
  logic [DW-1:0]   r_hi, r_lo;
  logic [NREG-1:0] r_busy;
  logic            w_wb, w_haz_a, w_haz_b;
  logic [NREG-1:0] w_set, w_clr;

  assign w_wb = Ww_rf && Wrn != 5'd0;
  // A register retiring this cycle is covered by the bypass, so it never stalls.
  assign w_haz_a = rs != 5'd0 && r_busy[rs] && !(Ww_rf && Wrn == rs);
  assign w_haz_b = rt != 5'd0 && r_busy[rt] && !(Ww_rf && Wrn == rt);
  assign stall   = (rs_used && w_haz_a) || (rt_used && w_haz_b);
  assign w_set   = (issue && !stall && issue_long && issue_rn != 5'd0) ? NREG'(1) << issue_rn : '0;
  assign w_clr   = w_wb ? NREG'(1) << Wrn : '0;
  assign qa      = rs == 5'd0 ? '0 : (Ww_rf && Wrn == rs) ? Wdata_rf : r_gpr[rs];
  assign qb      = rt == 5'd0 ? '0 : (Ww_rf && Wrn == rt) ? Wdata_rf : r_gpr[rt];
  assign hi_out  = Ww_hi ? Wdata_hi : r_hi;
  assign lo_out  = Ww_lo ? Wdata_lo : r_lo;
  assign busy    = r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_gpr[i] <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_busy <= '0;
    end else begin
      if (w_wb) r_gpr[Wrn] <= Wdata_rf;
      if (Ww_hi) r_hi <= Wdata_hi;
      if (Ww_lo) r_lo <= Wdata_lo;
      // Set after clear: a newer producer keeps the register busy.
      r_busy <= (r_busy & ~w_clr) | w_set;
    end
  end
endmodule
